// File: rtl/sme_job_feeder.sv
// sme_job_feeder: buffers one host job (optional string, then pattern) and replays it to the
// string matcher as contiguous bursts, returning the matcher result through a held handshake.
module sme_job_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_status
);
    localparam int SW = $clog2(STR_MAX + 1);
    localparam int PW = $clog2(PAT_MAX + 1);
    localparam int SA = $clog2(STR_MAX);
    localparam int PA = $clog2(PAT_MAX);
    localparam logic [SW-1:0] SMAX = SW'(STR_MAX);
    localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, SEND_S, SEND_P, WAIT, RESULT} state_t;
    state_t state, state_n;

    logic [7:0]    str_buf [STR_MAX];
    logic [7:0]    pat_buf [PAT_MAX];
    logic [SW-1:0] str_cnt, idx;
    logic [PW-1:0] pat_cnt, pat_cnt_n;
    logic [TW-1:0] timer;
    logic          str_loaded, str_job, trunc;
    logic          res_m;
    logic [4:0]    res_i;
    logic [1:0]    res_s;
    logic          take, take_s, take_p, str_ok, pat_ok, str_job_n, bad_job, str_end, pat_end;

    // String bytes arriving after any pattern byte are accepted but discarded.
    always_comb begin
        take      = state == LOAD && in_valid;
        take_s    = take && !in_kind && pat_cnt == '0;
        take_p    = take && in_kind;
        str_ok    = take_s && (!str_job || str_cnt < SMAX);
        pat_ok    = take_p && pat_cnt < PMAX;
        str_job_n = str_job || take_s;
        pat_cnt_n = pat_cnt + PW'(pat_ok);
        bad_job   = pat_cnt_n == '0 || (!str_job_n && !str_loaded);
        str_end   = idx == str_cnt - SW'(1);
        pat_end   = idx == SW'(pat_cnt - PW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = LOAD;
            LOAD:    if (take && in_last) state_n = bad_job ? RESULT : str_job_n ? SEND_S : SEND_P;
            SEND_S:  if (str_end) state_n = SEND_P;
            SEND_P:  if (pat_end) state_n = WAIT;
            WAIT:    if (sme_valid || timer == TMAX) state_n = RESULT;
            RESULT:  if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = state == LOAD;
        isstring   = state == SEND_S;
        ispattern  = state == SEND_P;
        chardata   = isstring ? str_buf[idx[SA-1:0]] : ispattern ? pat_buf[idx[PA-1:0]] : 8'h00;
        res_valid  = state == RESULT;
        res_match  = res_valid & res_m;
        res_index  = res_valid ? res_i : 5'd0;
        res_status = res_valid ? res_s : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (str_ok) str_buf[str_job ? str_cnt[SA-1:0] : '0] <= in_data;
        if (pat_ok) pat_buf[pat_cnt[PA-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_cnt    <= '0;
            pat_cnt    <= '0;
            idx        <= '0;
            timer      <= '0;
            str_loaded <= 1'b0;
            str_job    <= 1'b0;
            trunc      <= 1'b0;
            res_m      <= 1'b0;
            res_i      <= '0;
            res_s      <= '0;
        end else begin
            if (str_ok) str_cnt <= (str_job ? str_cnt : '0) + SW'(1);
            if (take_s) str_job <= 1'b1;
            if ((take_s && !str_ok) || (take_p && !pat_ok)) trunc <= 1'b1;
            pat_cnt <= pat_cnt_n;
            idx     <= state_n != state ? '0 : idx + SW'(1);
            timer   <= state == WAIT ? timer + TW'(1) : '0;
            if (state == SEND_S) str_loaded <= 1'b1;
            if (state == LOAD && state_n == RESULT) {res_m, res_i, res_s} <= {1'b0, 5'd0, 2'b11};
            if (state == WAIT && sme_valid) {res_m, res_i, res_s} <= {sme_match, sme_index, trunc, 1'b0};
            else if (state == WAIT && timer == TMAX) {res_m, res_i, res_s} <= {1'b0, 5'd0, 2'b01};
            // The string buffer and str_loaded survive so a pattern-only job can reuse them.
            if (state == RESULT && res_ready) begin
                pat_cnt <= '0;
                trunc   <= 1'b0;
                str_job <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sme_job_feeder.sv
// tb_sme_job_feeder: drives host jobs and a matcher stub, checking strobes and results
// against a queue-based reference model of the job rules.
module tb_sme_job_feeder;
    localparam int TIMEOUT = 255;

    logic clk = 0, reset = 1, in_valid = 0, in_kind = 0, in_last = 0;
    logic sme_valid = 0, sme_match = 0, res_ready = 0;
    logic [7:0] in_data = 0;
    logic [4:0] sme_index = 0;
    logic in_ready, isstring, ispattern, res_valid, res_match;
    logic [7:0] chardata;
    logic [4:0] res_index;
    logic [1:0] res_status;
    int tests = 0, fails = 0;

    sme_job_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match), .res_index(res_index),
        .res_status(res_status)
    );

    always #5 clk = ~clk;

    int cyc = 0, first = -1, last = -1, rv_cyc = -1, acc_cyc = 0;
    bit mon_en = 0, both = 0, stray = 0, order_bad = 0;
    logic [7:0] obs_s[$], obs_p[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (isstring && ispattern) both = 1;
            if (!isstring && !ispattern && chardata !== 8'h00) stray = 1;
            if (isstring || ispattern) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (isstring) begin
                obs_s.push_back(chardata);
                if (obs_p.size() != 0) order_bad = 1;
            end else if (ispattern) obs_p.push_back(chardata);
            if (res_valid && rv_cyc < 0) rv_cyc = cyc;
        end
    end

    bit job_k[$];
    logic [7:0] job_d[$];
    logic [7:0] m_str[$], exp_s[$], exp_p[$];
    bit m_loaded = 0, exp_bad, timed_out, hold_bad, post_rv;
    logic exp_rm, r_m;
    logic [4:0] exp_ri, r_i;
    logic [1:0] exp_rs, r_s;

    function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    task automatic new_job();
        job_k.delete();
        job_d.delete();
    endtask

    task automatic add(input string s, input bit k);
        for (int i = 0; i < s.len(); i++) begin
            job_k.push_back(k);
            job_d.push_back(s[i]);
        end
    endtask

    // Reference: string bytes fill the retained buffer (restarted by the job's first string
    // byte), pattern bytes fill a fresh buffer, overflow truncates, misordered bytes vanish.
    task automatic model_job(input int sdly, input logic m, input logic [4:0] ix);
        bit has_s, tr;
        logic [7:0] p[$];
        has_s = 0;
        tr = 0;
        for (int i = 0; i < job_k.size(); i++)
            if (!job_k[i]) begin
                if (p.size() != 0) continue;
                if (!has_s) begin has_s = 1; m_str.delete(); end
                if (m_str.size() < 32) m_str.push_back(job_d[i]); else tr = 1;
            end else if (p.size() < 8) p.push_back(job_d[i]);
            else tr = 1;
        exp_bad = p.size() == 0 || (!has_s && !m_loaded);
        exp_s.delete();
        exp_p.delete();
        if (!exp_bad) begin
            exp_p = p;
            if (has_s) begin exp_s = m_str; m_loaded = 1; end
        end
        if (exp_bad) {exp_rm, exp_ri, exp_rs} = {1'b0, 5'd0, 2'b11};
        else if (sdly < 0 || sdly > TIMEOUT) {exp_rm, exp_ri, exp_rs} = {1'b0, 5'd0, 2'b01};
        else {exp_rm, exp_ri, exp_rs} = {m, ix, tr ? 2'b10 : 2'b00};
    endtask

    task automatic start_mon();
        obs_s.delete();
        obs_p.delete();
        first = -1; last = -1; rv_cyc = -1;
        both = 0; stray = 0; order_bad = 0; timed_out = 0; hold_bad = 0;
        mon_en = 1;
    endtask

    task automatic send_job(input bit noise, input int gmax);
        for (int i = 0; i < job_k.size(); i++) begin
            bit acc;
            acc = 0;
            in_valid = 0;
            repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
            in_valid = 1;
            in_kind = job_k[i];
            in_data = job_d[i];
            in_last = i == job_k.size() - 1;
            sme_valid = noise && $urandom_range(0, 1) == 1;
            sme_match = 1;
            sme_index = 5'($urandom);
            for (int t = 0; t < 60 && !acc; t++) begin
                @(negedge clk); #1;
                if (in_ready) begin @(posedge clk); #1; acc = 1; end
            end
            sme_valid = 0;
            if (!acc) timed_out = 1;
        end
        in_valid = 0;
        in_last = 0;
        acc_cyc = cyc;
    endtask

    task automatic finish_job(input int sdly, input logic m, input logic [4:0] ix, input int rdly, input bit noise);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (res_valid || (first >= 0 && !isstring && !ispattern)) break;
        end
        if (!res_valid && sdly >= 0) begin
            repeat (sdly) begin @(negedge clk); #1; end
            sme_valid = 1; sme_match = m; sme_index = ix;
            @(negedge clk); #1;
            sme_valid = 0; sme_match = ~m; sme_index = ~ix;
        end
        for (int t = 0; t < 400 && !res_valid; t++) begin @(negedge clk); #1; end
        if (!res_valid) timed_out = 1;
        r_m = res_match; r_i = res_index; r_s = res_status;
        for (int t = 0; t < rdly; t++) begin
            sme_valid = noise && $urandom_range(0, 1) == 1;
            sme_index = 5'($urandom);
            @(negedge clk); #1;
            if (!res_valid || res_match !== r_m || res_index !== r_i || res_status !== r_s || in_ready !== 1'b0)
                hold_bad = 1;
        end
        sme_valid = 0;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        @(negedge clk); #1;
        post_rv = res_valid;
        mon_en = 0;
    endtask

    task automatic run_job(input int sdly, input logic m, input logic [4:0] ix, input int rdly, input bit noise, input int gmax);
        start_mon();
        send_job(noise, gmax);
        finish_job(sdly, m, ix, rdly, noise);
    endtask

    task automatic test_reset();
        reset = 1;
        m_loaded = 0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({in_ready, isstring, ispattern, chardata, res_valid, res_match, res_index, res_status} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {in_ready, isstring, ispattern, chardata, res_valid, res_match, res_index, res_status});
        end
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk); #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_idle_gap: in_ready got %b want 0", in_ready); end
        @(negedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_load: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_protocol();
        new_job(); add("ab", 1);
        model_job(4, 1, 3); run_job(4, 1, 3, 0, 0, 0);
        tests++;
        if (obs_s.size() + obs_p.size() != 0 || first != -1) begin
            fails++; $display("FAIL proto_patonly_strobes: got %0d strobes want 0", obs_s.size() + obs_p.size());
        end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs} || timed_out) begin
            fails++; $display("FAIL proto_patonly_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
        new_job(); add("s", 0);
        model_job(4, 1, 3); run_job(4, 1, 3, 0, 0, 0);
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs} || obs_s.size() != 0) begin
            fails++; $display("FAIL proto_stronly_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
        new_job(); add("xy", 0); add("p", 1); add("z", 0);
        model_job(3, 0, 7); run_job(3, 0, 7, 1, 0, 0);
        tests++;
        if (!same(obs_s, exp_s) || !same(obs_p, exp_p)) begin
            fails++; $display("FAIL proto_misorder_data: got %0d/%0d bytes want %0d/%0d", obs_s.size(), obs_p.size(), exp_s.size(), exp_p.size());
        end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++; $display("FAIL proto_misorder_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_basic();
        new_job(); add("ab de", 0); add("de", 1);
        model_job(4, 1, 3); run_job(4, 1, 3, 0, 0, 0);
        tests++;
        if (!same(obs_s, exp_s) || obs_s.size() != 5) begin
            fails++; $display("FAIL basic_string: got %0d bytes want %0d", obs_s.size(), exp_s.size());
        end
        tests++;
        if (!same(obs_p, exp_p)) begin fails++; $display("FAIL basic_pattern: got %0d bytes want %0d", obs_p.size(), exp_p.size()); end
        tests++;
        if (first - acc_cyc != 1) begin fails++; $display("FAIL basic_latency: got %0d want 1", first - acc_cyc); end
        tests++;
        if (last - first + 1 != 7) begin fails++; $display("FAIL basic_contiguous: got span %0d want 7", last - first + 1); end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs} || timed_out) begin
            fails++; $display("FAIL basic_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
        tests++;
        if (both || stray || order_bad) begin fails++; $display("FAIL basic_strobes: got both=%b stray=%b order=%b want 0", both, stray, order_bad); end
    endtask

    task automatic test_pattern_only();
        new_job(); add("ab", 1);
        model_job(3, 0, 9); run_job(3, 0, 9, 0, 0, 0);
        tests++;
        if (obs_s.size() != 0 || !same(obs_p, exp_p) || exp_p.size() != 2) begin
            fails++; $display("FAIL reuse_strobes: got %0d/%0d bytes want 0/%0d", obs_s.size(), obs_p.size(), exp_p.size());
        end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++; $display("FAIL reuse_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_trunc();
        new_job();
        for (int i = 0; i < 40; i++) begin job_k.push_back(0); job_d.push_back(8'($urandom)); end
        add("x", 1);
        model_job(6, 1, 17); run_job(6, 1, 17, 0, 0, 0);
        tests++;
        if (!same(obs_s, exp_s) || obs_s.size() != 32) begin
            fails++; $display("FAIL trunc_string: got %0d bytes want 32", obs_s.size());
        end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++; $display("FAIL trunc_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_timeout();
        new_job(); add("q", 0); add("r", 1);
        model_job(-1, 1, 4); run_job(-1, 1, 4, 0, 0, 0);
        tests++;
        if (rv_cyc - (last + 1) != TIMEOUT + 1) begin
            fails++; $display("FAIL timeout_latency: got %0d want %0d", rv_cyc - (last + 1), TIMEOUT + 1);
        end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs} || timed_out) begin
            fails++; $display("FAIL timeout_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
        new_job(); add("r", 1);
        model_job(TIMEOUT, 1, 21); run_job(TIMEOUT, 1, 21, 0, 0, 0);
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++; $display("FAIL timeout_valid_wins: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_hold();
        new_job(); add("k", 1);
        model_job(2, 1, 5); run_job(2, 1, 5, 10, 1, 0);
        tests++;
        if (hold_bad) begin fails++; $display("FAIL hold_stable: got changes during hold want none"); end
        tests++;
        if (post_rv !== 1'b0) begin fails++; $display("FAIL hold_release: res_valid got %b want 0", post_rv); end
        tests++;
        if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++; $display("FAIL hold_res: got %b/%0d/%b want %b/%0d/%b", r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_reset_mid();
        new_job();
        for (int i = 0; i < 20; i++) begin job_k.push_back(0); job_d.push_back(8'($urandom)); end
        add("z", 1);
        start_mon();
        send_job(0, 0);
        for (int t = 0; t < 20 && !isstring; t++) begin @(negedge clk); #1; end
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (isstring !== 1'b1) begin fails++; $display("FAIL rstmid_burst: isstring got %b want 1", isstring); end
        #1;
        reset = 1;
        #1;
        tests++;
        if ({in_ready, isstring, ispattern, chardata, res_valid, res_match, res_index, res_status} !== 20'h0) begin
            fails++;
            $display("FAIL rstmid_outputs: got %h want 0", {in_ready, isstring, ispattern, chardata, res_valid, res_match, res_index, res_status});
        end
        @(posedge clk); #1;
        reset = 0;
        m_loaded = 0;
        mon_en = 0;
        new_job(); add("hi", 0); add("j", 1);
        model_job(5, 1, 2); run_job(5, 1, 2, 0, 0, 0);
        tests++;
        if (!same(obs_s, exp_s) || !same(obs_p, exp_p) || {r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs}) begin
            fails++;
            $display("FAIL rstmid_next_job: got %0d/%0d bytes %b/%0d/%b want %0d/%0d bytes %b/%0d/%b",
                     obs_s.size(), obs_p.size(), r_m, r_i, r_s, exp_s.size(), exp_p.size(), exp_rm, exp_ri, exp_rs);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int sl, pl, sdly;
            logic m;
            logic [4:0] ix;
            sl = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
            pl = $urandom_range(0, 10);
            new_job();
            for (int i = 0; i < sl; i++) begin job_k.push_back(0); job_d.push_back(8'($urandom)); end
            for (int i = 0; i < pl; i++) begin job_k.push_back(1); job_d.push_back(8'($urandom)); end
            if ($urandom_range(0, 4) == 0 || job_k.size() == 0) begin job_k.push_back(pl == 0); job_d.push_back(8'($urandom)); end
            sdly = $urandom_range(0, 9) == 0 ? -1 : $urandom_range(0, 20);
            m = 1'($urandom);
            ix = 5'($urandom);
            model_job(sdly, m, ix);
            run_job(sdly, m, ix, $urandom_range(0, 3), 1, 2);
            tests++;
            if (!same(obs_s, exp_s) || !same(obs_p, exp_p)) begin
                fails++; $display("FAIL rand_data job %0d: got %0d/%0d bytes want %0d/%0d", n, obs_s.size(), obs_p.size(), exp_s.size(), exp_p.size());
            end
            tests++;
            if (exp_s.size() + exp_p.size() != 0 && (first - acc_cyc != 1 || last - first + 1 != exp_s.size() + exp_p.size())) begin
                fails++; $display("FAIL rand_timing job %0d: got latency %0d span %0d want 1/%0d", n, first - acc_cyc, last - first + 1, exp_s.size() + exp_p.size());
            end
            tests++;
            if ({r_m, r_i, r_s} !== {exp_rm, exp_ri, exp_rs} || timed_out || post_rv !== 1'b0) begin
                fails++; $display("FAIL rand_res job %0d: got %b/%0d/%b want %b/%0d/%b", n, r_m, r_i, r_s, exp_rm, exp_ri, exp_rs);
            end
            tests++;
            if (both || stray || order_bad || hold_bad) begin
                fails++; $display("FAIL rand_strobes job %0d: got both=%b stray=%b order=%b hold=%b want 0", n, both, stray, order_bad, hold_bad);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_protocol();
        test_basic();
        test_pattern_only();
        test_trunc();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
